// File: rtl/rv32i_types.sv
// Shared RV32M multiply definitions: funct3 codes, multiplier operand-type
// encodings and the sequencer FSM state.
package rv32i_types;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // Operand signedness seen by the multiplier: a-signed/b-signed.
    localparam logic [1:0] MUL_TYPE_UU = 2'b00;
    localparam logic [1:0] MUL_TYPE_SS = 2'b01;
    localparam logic [1:0] MUL_TYPE_SU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mul_state_e;

    // Reserved funct3 encodings fall through to plain MUL.
    function automatic logic [1:0] funct3_to_mul_type(input logic [2:0] funct3);
        case (funct3)
            F3_MULH:   return MUL_TYPE_SS;
            F3_MULHSU: return MUL_TYPE_SU;
            default:   return MUL_TYPE_UU;
        endcase
    endfunction

    function automatic logic is_high_half(input logic [2:0] funct3);
        return (funct3 == F3_MULH) || (funct3 == F3_MULHSU) || (funct3 == F3_MULHU);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; priority flips only when a grant is taken.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // Set when port 1 holds priority for the next tie; cleared so port 0 wins after reset.
    logic prio1_q;
    logic pick0;

    assign pick0 = req0 && (!req1 || !prio1_q);
    assign gnt0  = en && pick0;
    assign gnt1  = en && req1 && !pick0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio1_q <= 1'b0;
        end else if (gnt0) begin
            prio1_q <= 1'b1;
        end else if (gnt1) begin
            prio1_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Issues RV32M multiplies from two reservation stations to a shared
// multiplier and broadcasts the selected product half on the CDB.
module mul_sequencer
    import rv32i_types::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int ROB_IDX_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,

    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [2:0]                 req0_funct3,
    input  logic [OPERAND_WIDTH-1:0]   req0_rs1,
    input  logic [OPERAND_WIDTH-1:0]   req0_rs2,
    input  logic [ROB_IDX_W-1:0]       req0_rob_idx,

    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [2:0]                 req1_funct3,
    input  logic [OPERAND_WIDTH-1:0]   req1_rs1,
    input  logic [OPERAND_WIDTH-1:0]   req1_rs2,
    input  logic [ROB_IDX_W-1:0]       req1_rob_idx,

    output logic                       mul_start,
    output logic [1:0]                 mul_type,
    output logic [OPERAND_WIDTH-1:0]   mul_a,
    output logic [OPERAND_WIDTH-1:0]   mul_b,
    input  logic [2*OPERAND_WIDTH-1:0] mul_p,
    input  logic                       mul_done,

    output logic                       cdb_valid,
    input  logic                       cdb_ready,
    output logic [ROB_IDX_W-1:0]       cdb_rob_idx,
    output logic [OPERAND_WIDTH-1:0]   cdb_data
);

    mul_state_e                 state, state_next;
    logic [2:0]                 funct3_q;
    logic [OPERAND_WIDTH-1:0]   rs1_q, rs2_q, result_q;
    logic [ROB_IDX_W-1:0]       rob_q;
    logic                       kill_q;
    logic                       issue_en, grant0, grant1, accept, capture;

    // Waiting for mul_done to fall keeps a new start out of the multiplier's DONE state.
    assign issue_en = (state == IDLE) && !mul_done && !flush && !rst;
    assign accept   = grant0 || grant1;
    assign capture  = (state == BUSY) && mul_done && !kill_q && !flush;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (issue_en),
        .req0 (req0_valid),
        .req1 (req1_valid),
        .gnt0 (grant0),
        .gnt1 (grant1)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (mul_done) state_next = (kill_q || flush) ? IDLE : RESP;
            RESP:    if (flush || cdb_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mul_start  = 1'b0;
        cdb_valid  = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE:    begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                end
                BUSY:    mul_start = 1'b1;
                RESP:    cdb_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rob_q    <= '0;
            result_q <= '0;
            kill_q   <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q <= grant0 ? req0_funct3  : req1_funct3;
                rs1_q    <= grant0 ? req0_rs1     : req1_rs1;
                rs2_q    <= grant0 ? req0_rs2     : req1_rs2;
                rob_q    <= grant0 ? req0_rob_idx : req1_rob_idx;
            end
            if (capture) begin
                result_q <= is_high_half(funct3_q) ? mul_p[2*OPERAND_WIDTH-1:OPERAND_WIDTH]
                                                   : mul_p[OPERAND_WIDTH-1:0];
            end
            // A flush seen at any point of the multiply poisons its result.
            if (state == BUSY) kill_q <= (kill_q || flush) && !mul_done;
            else               kill_q <= 1'b0;
        end
    end

    assign mul_type    = funct3_to_mul_type(funct3_q);
    assign mul_a       = rs1_q;
    assign mul_b       = rs2_q;
    assign cdb_data    = result_q;
    assign cdb_rob_idx = rob_q;

endmodule
